shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one 4-bit rotate datapath between two independent requesters.
- Each requester issues rotate commands (data, amount, direction) over a valid/ready handshake.
- A round-robin arbiter grants one command per cycle into a single-entry registered output buffer, which drives a valid/ready result port tagged with the requester ID.
- The block sits between command sources and the downstream consumer of rotated nibbles.

Parameters:
- WIDTH, 4, data width. Fixed at 4 for the rotator; other values unsupported.
- AMT_W, 2, shift-amount width, equal to log2(WIDTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_data  input  WIDTH  requester 0 operand.
- req0_amt  input  AMT_W  requester 0 rotate amount, 0..3.
- req0_lft  input  1  requester 0 direction: 1 = rotate left, 0 = rotate right.
- req1_valid, req1_ready, req1_data, req1_amt, req1_lft: same as requester 0, for requester 1.
- out_valid  output  1  result buffer holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  rotated result.
- out_id  output  1  requester that produced the result.

Behaviour:
- Rotate function:
  - Left by n: out = (d << n) | (d >> (4-n)), truncated to 4 bits.
  - Right by n: out = (d >> n) | (d << (4-n)), truncated to 4 bits.
  - n = 0 passes d unchanged in either direction.
  - Rotate is combinational; its result is captured into the output buffer.
- Buffer free condition: free = !out_valid || out_ready. Same-cycle drain and refill is allowed, giving full throughput of one result per cycle.
- Arbitration:
  - Uses a last-served pointer, lst.
  - Only req0_valid set: grant requester 0.
  - Only req1_valid set: grant requester 1.
  - Both set: grant the requester != lst.
  - lst updates to the granted ID only on an accepted transfer.
- Ready generation:
  - reqX_ready = free && (grant == X) && !rst.
  - At most one reqX_ready is high in any cycle.
  - Ready may depend combinationally on valid and on out_ready.
  - A requester must hold valid, data, amt and lft stable until it sees ready.
- Accept (reqX_valid && reqX_ready):
  - Next edge: out_data = rotate(reqX_data, reqX_amt, reqX_lft), out_id = X, out_valid = 1.
  - Latency from accept to out_valid is 1 cycle.
- Drain:
  - out_valid && out_ready with no new accept: out_valid goes to 0 on the next edge.
  - out_data and out_id hold their last value.
- Backpressure: while out_valid && !out_ready, out_data, out_id and out_valid are stable and both readies are 0.
- Buffer states:
  - EMPTY: out_valid = 0.
    - Accept: go to FULL.
  - FULL: out_valid = 1.
    - out_ready with accept: stay FULL with new data.
    - out_ready without accept: go to EMPTY.
    - !out_ready: stay FULL.
- Reset values: out_valid = 0, out_data = 0, out_id = 0, lst = 1 (requester 0 wins the first contention), req0_ready = req1_ready = 0.
  - Reset mid-operation discards a pending result without a handshake.
  - A command presented during the reset cycle is not accepted.
- Fairness: under continuous contention, grants alternate 0, 1, 0, 1, ...; no requester waits more than one accepted transfer.

Test Plan:
- Reset, then req0 data 4'b1001 amt 1 lft 1 (out_ready = 1) -> req0_ready = 1 in the same cycle; next cycle out_valid = 1, out_data = 4'b0011, out_id = 0.
- req1 data 4'b1001 amt 1 lft 0, then amt 3 lft 1, then amt 0 -> results 4'b1100, 4'b1100, 4'b1001, all with out_id = 1, on consecutive cycles.
- Both valid continuously after reset, out_ready = 1, req0 data 4'h1, req1 data 4'h8, amt 0 -> out_id sequence 0, 1, 0, 1; out_data 1, 8, 1, 8; one result per cycle.
- out_ready = 0 for 3 cycles with a result pending (4'b0110) -> out_data stays 4'b0110, both readies 0. Raise out_ready with req0 valid -> drain and refill in the same cycle, no gap.
- Assert rst while out_valid = 1 and req1 valid -> next cycle out_valid = 0, out_data = 0, out_id = 0. First contention after release grants requester 0.
- Single requester toggling valid (req1 only, 5 commands with gaps) -> every command accepted the first cycle it is valid; lst does not block a lone requester.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one nibble rotator. A round-robin
// arbiter feeds a single-entry registered result buffer with an ID tag.
module shift_arbiter #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_lft,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_lft,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic             lft;
    } cmd_t;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    buf_state_t       state, state_nxt;
    cmd_t [1:0]       cmd;
    logic [1:0]       req_valid;
    logic             grant;
    logic             lst;
    logic             free;
    logic             accept;

    // Rotating the doubled word lets one shift cover the wrap-around bits.
    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] d,
                                                input logic [AMT_W-1:0] n,
                                                input logic lft);
        logic [2*WIDTH-1:0] dd;
        dd = {d, d};
        if (lft) begin
            dd = dd << n;
            return dd[2*WIDTH-1:WIDTH];
        end
        dd = dd >> n;
        return dd[WIDTH-1:0];
    endfunction

    assign cmd[0]    = '{data: req0_data, amt: req0_amt, lft: req0_lft};
    assign cmd[1]    = '{data: req1_data, amt: req1_amt, lft: req1_lft};
    assign req_valid = {req1_valid, req0_valid};

    assign out_valid = (state == FULL);
    assign free      = !out_valid || out_ready;

    // Round-robin pick: a lone requester always wins; on contention the one
    // not served last wins. With nobody asking, point at the next in turn.
    always_comb begin
        grant = ~lst;
        if (req_valid == 2'b01)
            grant = 1'b0;
        else if (req_valid == 2'b10)
            grant = 1'b1;
    end

    assign req0_ready = free && !grant && !rst;
    assign req1_ready = free &&  grant && !rst;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Buffer occupancy: refill wins over drain so back-to-back results flow.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (out_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Occupancy register; reset drops any pending result.
    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Result payload and last-served pointer advance only on an accepted
    // command; lst resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_id   <= 1'b0;
            lst      <= 1'b1;
        end else if (accept) begin
            out_data <= rotate(cmd[grant].data, cmd[grant].amt, cmd[grant].lft);
            out_id   <= grant;
            lst      <= grant;
        end
    end

endmodule
